// File: rtl/gcd_engine_if.sv
// Host-side bundle for the GCD coprocessor: start/abort request plus
// operands in, busy/done status and results out.
interface gcd_engine_if #(
    parameter int WIDTH = 16,
    parameter int ITW   = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [ITW-1:0]   iters;
    logic             err;

    modport master (
        output start, abort, a_in, b_in,
        input  busy, done, result, iters, err
    );

    modport slave (
        input  start, abort, a_in, b_in,
        output busy, done, result, iters, err
    );
endinterface

// File: rtl/gcd_engine.sv
// Subtractive GCD coprocessor: Moore control FSM plus A/B datapath with
// zero-operand handling, 0/0 error flag, abort and a saturating step counter.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int ITW   = 16
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMP  = 3'd1;
    localparam logic [2:0] S_SUBA = 3'd2;
    localparam logic [2:0] S_SUBB = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [ITW-1:0] ITERS_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [ITW-1:0]   iters_q, iters_d;
    logic             err_q, err_d;
    logic [ITW-1:0]   iters_inc;

    assign iters_inc = (iters_q == ITERS_MAX) ? iters_q : iters_q + ITW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        iters_d  = iters_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    iters_d = '0;
                    err_d   = 1'b0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (a_q == '0 || b_q == '0) begin
                    result_d = a_q | b_q;
                    err_d    = (a_q == '0) && (b_q == '0);
                    state_d  = S_FIN;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    state_d  = S_FIN;
                end else if (a_q > b_q) begin
                    state_d = S_SUBA;
                end else begin
                    state_d = S_SUBB;
                end
            end
            S_SUBA: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    a_d     = a_q - b_q;
                    iters_d = iters_inc;
                    state_d = S_CMP;
                end
            end
            S_SUBB: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    b_d     = b_q - a_q;
                    iters_d = iters_inc;
                    state_d = S_CMP;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            iters_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            iters_q  <= iters_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q == S_CMP) || (state_q == S_SUBA) || (state_q == S_SUBB);
    assign bus.done   = (state_q == S_FIN);
    assign bus.result = result_q;
    assign bus.iters  = iters_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: closed-form GCD/step model, per-cycle
// compare process, directed latency cases and randomized runs with abort.
module tb_gcd_engine;
    localparam int WIDTH = 16;
    localparam int ITW   = 8;
    localparam longint IT_MAX = (64'd1 << ITW) - 1;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    gcd_engine_if #(.WIDTH(WIDTH), .ITW(ITW)) bus ();

    gcd_engine #(.WIDTH(WIDTH), .ITW(ITW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of subtract steps, using quotients instead of single subtractions.
    function automatic longint ref_steps(input longint a_in, input longint b_in);
        longint a, b, k, s;
        a = a_in; b = b_in; s = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) begin k = (a - 1) / b; a = a - k * b; end
            else       begin k = (b - 1) / a; b = b - k * a; end
            s = s + k;
        end
        return s;
    endfunction

    function automatic longint ref_gcd(input longint a_in, input longint b_in);
        longint a, b, t;
        a = a_in; b = b_in;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    function automatic longint sat_it(input longint s);
        return (s > IT_MAX) ? IT_MAX : s;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 busy (counting down cycles), 2 fin.
    int     m_phase;
    int     m_rem;
    longint m_res, m_it, m_err;
    longint p_res, p_it, p_err;
    bit     m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_rem <= 0;
            m_res <= 0; m_it <= 0; m_err <= 0; m_valid <= 1'b1;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase <= 1;
                    m_rem   <= 2 * int'(ref_steps(bus.a_in, bus.b_in)) + 1;
                    p_res   <= ref_gcd(bus.a_in, bus.b_in);
                    p_it    <= sat_it(ref_steps(bus.a_in, bus.b_in));
                    p_err   <= (bus.a_in == 0 && bus.b_in == 0) ? 1 : 0;
                    m_valid <= 1'b0;
                end
                1: if (bus.abort) m_phase <= 0;
                   else begin
                       m_rem <= m_rem - 1;
                       if (m_rem == 1) begin
                           m_phase <= 2;
                           m_res <= p_res; m_it <= p_it; m_err <= p_err;
                           m_valid <= 1'b1;
                       end
                   end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", longint'(bus.busy), (m_phase == 1) ? 1 : 0);
        chk("done", longint'(bus.done), (m_phase == 2) ? 1 : 0);
        if (m_valid && m_phase != 1) begin
            chk("result", longint'(bus.result), m_res);
            chk("iters", longint'(bus.iters), m_it);
            chk("err", longint'(bus.err), m_err);
        end
    end

    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = WIDTH'($urandom);
        bus.b_in  = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy || bus.done) begin
            failures++;
            $display("FAIL timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic directed(input longint a, input longint b, input longint er,
                            input longint ei, input longint ee, input int ecyc);
        int k;
        do_start(WIDTH'(a), WIDTH'(b));
        k = 1;
        while (!bus.done && k < 2000) begin @(negedge clk); k++; end
        chk("done_cycle", k, ecyc);
        chk("dir_result", longint'(bus.result), er);
        chk("dir_iters", longint'(bus.iters), ei);
        chk("dir_err", longint'(bus.err), ee);
        $display("txn directed a=%0d b=%0d result=%0d iters=%0d err=%0d cycles=%0d",
                 a, b, bus.result, bus.iters, bus.err, k);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.a_in = '0; bus.b_in = '0;

        // Pin the model against hand-computed values.
        chk("model_gcd_12_8", ref_gcd(12, 8), 4);
        chk("model_steps_12_8", ref_steps(12, 8), 2);
        chk("model_gcd_48_18", ref_gcd(48, 18), 6);
        chk("model_steps_48_18", ref_steps(48, 18), 4);
        chk("model_steps_7_7", ref_steps(7, 7), 0);
        chk("model_gcd_0_9", ref_gcd(0, 9), 9);
        chk("model_steps_65535_1", ref_steps(65535, 1), 65534);
        chk("model_sat_65534", sat_it(65534), 255);

        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_result", longint'(bus.result), 0);
        rst = 1'b0;

        directed(12, 8, 4, 2, 0, 6);
        directed(48, 18, 6, 4, 0, 10);
        directed(7, 7, 7, 0, 0, 2);
        directed(0, 9, 9, 0, 0, 2);
        directed(0, 0, 0, 0, 1, 2);
        directed(65535, 21845, 21845, 2, 0, 6);
        directed(65535, 65535, 65535, 0, 0, 2);
        directed(300, 1, 1, 255, 0, 600);

        // Asynchronous reset in the middle of a run.
        do_start(16'd48, 16'd18);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", longint'(bus.busy), 0);
        chk("arst_done", longint'(bus.done), 0);
        chk("arst_result", longint'(bus.result), 0);
        chk("arst_iters", longint'(bus.iters), 0);
        chk("arst_err", longint'(bus.err), 0);
        $display("txn reset mid-run a=48 b=18");
        @(negedge clk);
        rst = 1'b0;
        directed(48, 18, 6, 4, 0, 10);

        // Abort at cycle 3, then a fresh start.
        do_start(16'd48, 16'd18);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_done", longint'(bus.done), 0);
        $display("txn abort a=48 b=18 at cycle 3");
        directed(21, 14, 7, 2, 0, 6);

        // Start while busy must not disturb the running operands.
        do_start(16'd48, 16'd18);
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 16'd5; bus.b_in = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && bus.busy) @(negedge clk);
        chk("busy_start_result", longint'(bus.result), 6);
        $display("txn start-while-busy a=48 b=18 result=%0d", bus.result);
        wait_idle();

        // Randomized runs with occasional abort and ignored starts.
        for (int t = 0; t < 40; t++) begin
            logic [WIDTH-1:0] ra, rb;
            int mode;
            ra = WIDTH'($urandom_range(0, 400));
            rb = WIDTH'($urandom_range(0, 400));
            if ($urandom_range(0, 9) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = '0;
            mode = int'($urandom_range(0, 4));
            do_start(ra, rb);
            if (mode == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
            end else if (mode == 1) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_idle();
            $display("txn random a=%0d b=%0d mode=%0d result=%0d iters=%0d err=%0d",
                     ra, rb, mode, bus.result, bus.iters, bus.err);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
